flop_chain_scoreboard: RTL and testbench

//  Cycle-accurate checker downstream of the prsim-cosimulated HAC_POS_FLOP chain.

---
 rtl/fcs_pkg.sv | 30 +++
 rtl/fcs_ref_shift.sv | 43 ++++
 rtl/flop_chain_scoreboard.sv | 145 ++++++++++++++
 tb/tb_flop_chain_scoreboard.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fcs_pkg.sv
// Shared types and helpers for the flop-chain scoreboard.
package fcs_pkg;

  // Scoreboard control states.
  typedef enum logic [1:0] {
    FCS_IDLE  = 2'd0,
    FCS_FILL  = 2'd1,
    FCS_CHECK = 2'd2
  } fcs_state_e;

  // Widest counter that sat_inc can handle.
  localparam int FCS_MAX_W = 64;

  // Increment 'value' as a 'width'-bit counter, holding at all-ones.
  function automatic logic [FCS_MAX_W-1:0] sat_inc(input logic [FCS_MAX_W-1:0] value,
                                                   input int width);
    logic [FCS_MAX_W-1:0] mask;
    if (width >= FCS_MAX_W) begin
      mask = {FCS_MAX_W{1'b1}};
    end else begin
      mask = (64'd1 << width) - 64'd1;
    end
    if ((value & mask) == mask) begin
      sat_inc = mask;
    end else begin
      sat_inc = (value + 64'd1) & mask;
    end
  endfunction

endpackage

// File: rtl/fcs_ref_shift.sv
// Reference model of the flop chain: a DEPTH-stage shift register that is
// flushed to zero whenever checking is disabled. Exposes the last stage.
module fcs_ref_shift #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic din,
  output logic tap
);

  logic [DEPTH-1:0] stages;

  generate
    if (DEPTH == 1) begin : g_single
      // Single stage: capture din while enabled, clear when idle.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stages <= 1'b0;
        end else if (!en) begin
          stages <= 1'b0;
        end else begin
          stages <= din;
        end
      end
    end else begin : g_multi
      // Shift din towards the tap while enabled, clear when idle.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stages <= '0;
        end else if (!en) begin
          stages <= '0;
        end else begin
          stages <= {stages[DEPTH-2:0], din};
        end
      end
    end
  endgenerate

  assign tap = stages[DEPTH-1];

endmodule

// File: rtl/flop_chain_scoreboard.sv
// Cycle-accurate checker for a flop chain returned from co-simulation.
// A reference shift register tracks the stimulus; once DEPTH enabled edges
// have filled it, every edge compares the chain output against its tap.
module flop_chain_scoreboard
  import fcs_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int MAX_ERR = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic             dut_q,
  output logic             mismatch,
  output logic             x_seen,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cmp_count,
  output logic             fail
);

  localparam int FILL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);

  fcs_state_e state;
  fcs_state_e next_state;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;

  logic ref_tap;
  logic do_cmp;
  logic cmp_x;
  logic cmp_diff;
  logic fail_next;
  logic [FCS_MAX_W-1:0] err_inc;
  logic [FCS_MAX_W-1:0] cmp_inc;
  logic [FCS_MAX_W-1:0] err_after;
  logic unused_hi;

  fcs_ref_shift #(.DEPTH(DEPTH)) u_ref (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .din   (din),
    .tap   (ref_tap)
  );

  // State and fill counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FCS_IDLE;
      fill  <= '0;
    end else begin
      state <= next_state;
      fill  <= fill_next;
    end
  end

  // Next-state logic: fill counts enabled edges so the first compare lands
  // exactly DEPTH edges after checking starts.
  always_comb begin
    next_state = state;
    fill_next  = fill;
    if (!en) begin
      next_state = FCS_IDLE;
      fill_next  = '0;
    end else begin
      case (state)
        FCS_IDLE: begin
          // A one-stage chain is already valid after the first enabled edge.
          if (DEPTH == 1) begin
            next_state = FCS_CHECK;
            fill_next  = '0;
          end else begin
            next_state = FCS_FILL;
            fill_next  = FILL_W'(1);
          end
        end
        FCS_FILL: begin
          if (fill == FILL_LAST) begin
            next_state = FCS_CHECK;
            fill_next  = '0;
          end else begin
            next_state = FCS_FILL;
            fill_next  = fill + FILL_W'(1);
          end
        end
        FCS_CHECK: begin
          next_state = FCS_CHECK;
          fill_next  = '0;
        end
        default: begin
          next_state = FCS_IDLE;
          fill_next  = '0;
        end
      endcase
    end
  end

  // Compare decode: X/Z on the chain output is always treated as a mismatch.
  always_comb begin
    do_cmp   = (state == FCS_CHECK) && en;
    cmp_x    = (dut_q !== 1'b0) && (dut_q !== 1'b1);
    cmp_diff = cmp_x || (dut_q !== ref_tap);
    err_inc  = sat_inc(FCS_MAX_W'(err_count), CNT_W);
    cmp_inc  = sat_inc(FCS_MAX_W'(cmp_count), CNT_W);
    if (do_cmp && cmp_diff) begin
      err_after = err_inc;
    end else begin
      err_after = FCS_MAX_W'(err_count);
    end
    if ((MAX_ERR != 0) && (err_after >= FCS_MAX_W'(MAX_ERR))) begin
      fail_next = 1'b1;
    end else begin
      fail_next = fail;
    end
  end

  assign unused_hi = ^{err_inc, cmp_inc};

  // Output registers: mismatch pulse, sticky flags and saturating counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch  <= 1'b0;
      x_seen    <= 1'b0;
      err_count <= '0;
      cmp_count <= '0;
      fail      <= 1'b0;
    end else begin
      mismatch <= do_cmp && cmp_diff;
      fail     <= fail_next;
      if (do_cmp) begin
        cmp_count <= cmp_inc[CNT_W-1:0];
        if (cmp_diff) begin
          err_count <= err_inc[CNT_W-1:0];
        end
        if (cmp_x) begin
          x_seen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_flop_chain_scoreboard.sv
// Self-checking bench for flop_chain_scoreboard. Instance A uses the default
// parameters; instance B uses a 4-bit counter with failing disabled.
module tb_flop_chain_scoreboard;

  localparam int DEPTH       = 4;
  localparam int HALF_PERIOD = 50;

  logic clk = 1'b0;
  logic reset;

  logic        en_a, din_a, q_a;
  logic        mm_a, xs_a, fail_a;
  logic [15:0] err_a, cmp_a;

  logic        en_b, din_b, q_b;
  logic        mm_b, xs_b, fail_b;
  logic [3:0]  err_b, cmp_b;

  int total = 0;
  int bad   = 0;

  // Behavioural model state for instance A.
  logic chain[$];   // last DEPTH stimulus bits, models a correct chain
  logic hist[$];    // stimulus seen in the current enabled run
  int   m_cmp, m_err;
  logic m_mm, m_x, m_fail;

  flop_chain_scoreboard #(.DEPTH(DEPTH), .CNT_W(16), .MAX_ERR(1)) u_dut_a (
    .clk(clk), .reset(reset), .en(en_a), .din(din_a), .dut_q(q_a),
    .mismatch(mm_a), .x_seen(xs_a), .err_count(err_a), .cmp_count(cmp_a), .fail(fail_a)
  );

  flop_chain_scoreboard #(.DEPTH(DEPTH), .CNT_W(4), .MAX_ERR(0)) u_dut_b (
    .clk(clk), .reset(reset), .en(en_b), .din(din_b), .dut_q(q_b),
    .mismatch(mm_b), .x_seen(xs_b), .err_count(err_b), .cmp_count(cmp_b), .fail(fail_b)
  );

  always #HALF_PERIOD clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_cmp = 0; m_err = 0; m_mm = 1'b0; m_x = 1'b0; m_fail = 1'b0;
  endtask

  task automatic check_a(input string tag);
    chk({tag, ".mismatch"}, 16'(mm_a), 16'(m_mm));
    chk({tag, ".x_seen"},   16'(xs_a), 16'(m_x));
    chk({tag, ".err"},      err_a,     16'(m_err));
    chk({tag, ".cmp"},      cmp_a,     16'(m_cmp));
    chk({tag, ".fail"},     16'(fail_a), 16'(m_fail));
  endtask

  // One clock of instance A. mode: 0 correct chain, 1 inverted, 2 X.
  task automatic step_a(input string tag, input logic e, input logic d, input int mode);
    logic correct, q, expv, isx;
    correct = (chain.size() == DEPTH) ? chain[0] : 1'b0;
    if (mode == 1)      q = ~correct;
    else if (mode == 2) q = 1'bx;
    else                q = correct;
    en_a = e; din_a = d; q_a = q;
    @(posedge clk);
    chain.push_back(d);
    if (chain.size() > DEPTH) void'(chain.pop_front());
    m_mm = 1'b0;
    if (e) begin
      if (hist.size() == DEPTH) begin
        expv = hist[0];
        isx  = (q !== 1'b0) && (q !== 1'b1);
        m_mm = isx || (q !== expv);
        if (m_cmp < 65535) m_cmp++;
        if (m_mm && m_err < 65535) m_err++;
        if (isx) m_x = 1'b1;
        if (m_err >= 1) m_fail = 1'b1;
      end
      hist.push_back(d);
      if (hist.size() > DEPTH) void'(hist.pop_front());
    end else begin
      hist.delete();
    end
    #1;
    check_a(tag);
  endtask

  initial begin
    int saved;
    int nc;
    logic bh[$];
    logic qb;
    logic [4:0] pattern;

    reset = 1'b1;
    en_a = 1'b0; din_a = 1'b0; q_a = 1'b0;
    en_b = 1'b0; din_b = 1'b0; q_b = 1'b0;
    model_reset();
    #1;
    check_a("reset");
    chk("reset.b_cmp", 16'(cmp_b), 16'd0);
    @(posedge clk);
    #10 reset = 1'b0;

    // 1: fixed pattern then random stimulus through a correct chain.
    pattern = 5'b10110;
    for (int i = 0; i < 5; i++) step_a("pat", 1'b1, pattern[i], 0);
    chk("pat.first_cmp", cmp_a, 16'd1);
    for (int i = 0; i < 15; i++) step_a("rnd", 1'b1, 1'($urandom), 0);

    // 2: one inverted slot sets fail, which then stays set.
    step_a("inv", 1'b1, 1'($urandom), 1);
    chk("inv.fail", 16'(fail_a), 16'd1);
    for (int i = 0; i < 6; i++) step_a("post_inv", 1'b1, 1'($urandom), 0);

    // 3: X on the chain output.
    step_a("xq", 1'b1, 1'($urandom), 2);
    for (int i = 0; i < 3; i++) step_a("post_x", 1'b1, 1'($urandom), 0);

    // 4: drop en for one cycle, compares pause for DEPTH enabled edges.
    saved = m_cmp;
    step_a("en_low", 1'b0, 1'($urandom), 0);
    for (int i = 0; i < DEPTH; i++) step_a("refill", 1'b1, 1'($urandom), 0);
    chk("refill.cmp_held", cmp_a, 16'(saved));
    for (int i = 0; i < 6; i++) step_a("resume", 1'b1, 1'($urandom), 0);
    chk("resume.cmp", cmp_a, 16'(saved + 6));

    // Bring err_count up to three before the mid-check reset.
    for (int i = 0; i < 5 && m_err < 3; i++) step_a("more_err", 1'b1, 1'($urandom), 1);
    chk("pre_reset.err", err_a, 16'd3);

    // 5: asynchronous reset between edges.
    #20 reset = 1'b1;
    #1;
    model_reset();
    check_a("async_rst");
    #5 reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) step_a("rst_fill", 1'b1, 1'($urandom), 0);
    chk("rst_fill.cmp", cmp_a, 16'd0);
    for (int i = 0; i < 10; i++)
      step_a("rst_run", 1'b1, 1'($urandom), ($urandom_range(0, 7) == 0) ? 1 : 0);

    // 6: saturation on the 4-bit instance with failing disabled.
    en_a = 1'b0;
    for (int k = 1; k <= DEPTH + 20; k++) begin
      qb = (bh.size() == DEPTH) ? ~bh[0] : 1'b0;
      en_b = 1'b1; din_b = 1'($urandom); q_b = qb;
      @(posedge clk);
      bh.push_back(din_b);
      if (bh.size() > DEPTH) void'(bh.pop_front());
      #1;
      nc = (k > DEPTH) ? k - DEPTH : 0;
      if (nc > 15) nc = 15;
      chk("sat.cmp", 16'(cmp_b), 16'(nc));
      chk("sat.err", 16'(err_b), 16'(nc));
      chk("sat.mismatch", 16'(mm_b), (k > DEPTH) ? 16'd1 : 16'd0);
      chk("sat.fail", 16'(fail_b), 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
